bus_arbiter_mux: RTL
====================

Name: bus_arbiter_mux

Overview:
Parametrised, registered bus multiplexer for the datapath. It takes NSRC out-enable strobes and NSRC flattened data words. Each cycle it arbitrates among the active strobes using fixed-priority or round-robin policy, and registers the winner's word onto the bus. It also reports the granted index and one-hot grant, and flags and counts multi-driver contention.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 24, number of sources; any value from 2 to 64; need not be a power of 2.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- HOLD_IDLE, 1, 1 = bus_out holds its last value when no strobe is active; 0 = bus_out drives 0 when idle.
- SELW (localparam), $clog2(NSRC), width of grant_idx.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  reset; asynchronous, active-low.
- src_data  in  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  in  NSRC  per-source out-enable strobes.
- err_clear  in  1  synchronous clear of contention_cnt.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high when bus_out was driven by a granted source in the prior cycle.
- grant_idx  out  SELW  index of the registered winner.
- grant_onehot  out  NSRC  one-hot form of grant_idx; all zero when idle.
- contention  out  1  registered pulse: two or more strobes were active in the sampled cycle.
- contention_cnt  out  16  saturating count of contention cycles.

Behaviour:
- Reset (clear=0, asynchronous):
  - bus_out=0, bus_valid=0, grant_idx=0, grant_onehot=0, contention=0, contention_cnt=0.
  - Round-robin pointer=NSRC-1, so the first search starts at index 0.
  - FSM enters IDLE.
  - Deassertion of clear is sampled at a clock edge; the first arbitration happens on the first edge with clear=1.
- Latency: strobes and data sampled at edge t appear on all outputs after edge t (exactly 1 cycle). No combinational path from inputs to outputs.
- FSM, two states:
  - IDLE: bus_valid=0. On any src_out bit set -> DRIVE.
  - DRIVE: bus_valid=1. Stays in DRIVE while any strobe is active; goes to IDLE when src_out is all zero.
- Fixed priority: winner is the lowest set bit of src_out.
- Round-robin:
  - Search starts at pointer+1 and wraps from NSRC-1 to 0 (modulo NSRC, not a power of 2).
  - Winner is the first set bit found.
  - Pointer updates to the winner only when a grant is issued; idle cycles leave it unchanged.
  - A single requester is always granted immediately.
- Idle cycle (src_out=0):
  - bus_valid=0, grant_onehot=0, grant_idx holds its value.
  - bus_out holds its value if HOLD_IDLE=1, else becomes 0.
- Contention:
  - contention=1 for exactly the cycle following any sample with popcount(src_out)>=2.
  - The winner is still driven normally.
  - contention_cnt increments by 1 per contention cycle and saturates at 16'hFFFF (no wrap).
- err_clear: contention_cnt becomes 0 on the next edge. If err_clear and contention occur on the same edge, err_clear wins (count=0). The contention pulse itself is unaffected.
- Reset asserted mid-operation: all state returns immediately to reset values; the pointer restarts at NSRC-1.
- src_out bits at index >= NSRC do not exist. No X is ever driven: the default/idle path is defined by HOLD_IDLE.

Decomposition:
- Shared package bus_pkg holds:
  - ARB_FIXED=0, ARB_RR=1.
  - CONT_CNT_W=16.
  - FSM state typedef {IDLE, DRIVE}.
- One sub-module, bus_rr_arbiter: combinational grant logic (NSRC, ARB_MODE, pointer input -> one-hot grant and index, plus a multi-request flag).
- The parent holds the pointer, FSM, output registers and counter.

Test Plan:
- Fixed mode, src_out bits 5 and 20 set, src5=32'hA5A5_0005, src20=32'h0000_0014 -> next cycle: bus_out=32'hA5A5_0005, grant_idx=5, bus_valid=1, contention=1, contention_cnt=1.
- Round-robin, all 24 strobes held high for 26 cycles from reset -> grant_idx sequence 0,1,...,23,0,1. Confirms wrap at NSRC-1.
- Round-robin, pointer=23 after granting src23, then only src3 requests -> grant_idx=3; an idle cycle follows, then src3 and src4 request -> grant_idx=4.
- Single strobe src7=32'hDEAD_BEEF for 1 cycle, then idle -> cycle 1: bus_out=32'hDEAD_BEEF, bus_valid=1; cycle 2: bus_valid=0, grant_onehot=0, and bus_out=32'hDEAD_BEEF (HOLD_IDLE=1) or 0 (HOLD_IDLE=0).
- Force contention for 70000 cycles -> contention_cnt saturates at 16'hFFFF. Then assert err_clear together with a contention sample -> contention_cnt=0, contention=1.
- Drive src2 continuously; assert clear low between edges -> all outputs 0 immediately with no clock. On release, the next edge gives grant_idx=2 and bus_valid=1.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and types for the registered bus arbiter/multiplexer.
package bus_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;
    localparam int CONT_CNT_W = 16;

    typedef enum logic {
        IDLE,
        DRIVE
    } bus_state_e;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational grant logic: fixed priority (lowest index) or round-robin starting after ptr.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NSRC     = 24,
    parameter int ARB_MODE = ARB_FIXED,
    localparam int SELW    = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [NSRC-1:0] grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any_req,
    output logic            multi_req
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NSRC; i++) begin
            // Modulo wrap keeps the search inside 0..NSRC-1 for non power-of-two NSRC.
            if (ARB_MODE == ARB_RR) begin
                cand = (int'(ptr) + 1 + i) % NSRC;
            end else begin
                cand = i;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = SELW'(cand);
            end
        end
    end

    assign any_req   = |req;
    assign multi_req = ($countones(req) >= 2);

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer: arbitrates NSRC strobes, registers the winner's word,
// reports the grant, and flags/counts multi-driver contention.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 24,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int HOLD_IDLE = 1,
    localparam int SELW     = $clog2(NSRC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  err_clear,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [SELW-1:0]       grant_idx,
    output logic [NSRC-1:0]       grant_onehot,
    output logic                  contention,
    output logic [CONT_CNT_W-1:0] contention_cnt
);

    bus_state_e       state;
    logic [SELW-1:0]  rr_ptr;
    logic [NSRC-1:0]  win_onehot;
    logic [SELW-1:0]  win_idx;
    logic             any_req;
    logic             multi_req;
    logic [WIDTH-1:0] sel_data;

    bus_rr_arbiter #(
        .NSRC     (NSRC),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req       (src_out),
        .ptr       (rr_ptr),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .any_req   (any_req),
        .multi_req (multi_req)
    );

    // AND-OR mux: never indexes past the last source, and yields 0 with no grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (win_onehot[i]) begin
                sel_data = sel_data | src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state          <= IDLE;
            rr_ptr         <= SELW'(NSRC - 1);
            bus_out        <= '0;
            bus_valid      <= 1'b0;
            grant_idx      <= '0;
            grant_onehot   <= '0;
            contention     <= 1'b0;
            contention_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= DRIVE;
                        bus_valid <= 1'b1;
                    end else begin
                        bus_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!any_req) begin
                        state     <= IDLE;
                        bus_valid <= 1'b0;
                    end else begin
                        bus_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_valid <= 1'b0;
                end
            endcase

            if (any_req) begin
                bus_out      <= sel_data;
                grant_idx    <= win_idx;
                grant_onehot <= win_onehot;
                rr_ptr       <= win_idx;
            end else begin
                grant_onehot <= '0;
                if (HOLD_IDLE == 0) begin
                    bus_out <= '0;
                end
            end

            contention <= multi_req;
            // err_clear takes precedence over a coincident contention increment.
            if (err_clear) begin
                contention_cnt <= '0;
            end else if (multi_req && (contention_cnt != {CONT_CNT_W{1'b1}})) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end

endmodule
